uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 85 ++++++++
 tb/tb_uart_rx_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Byte FIFO fed by a 4-phase REQ/ACK serial-receiver handshake, with a FWFT read side.
// One write is made per handshake. Bytes that arrive while the FIFO is full are dropped and flagged as overrun.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          RCV_REQ,
   input  logic [7:0]    RCV_Data,
   output logic          RCV_ACK,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overrun,
   input  logic          ovr_clr
);

   localparam int unsigned CW = AW + 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] ACKD = 1'b1;

   logic [0:0]    state;
   logic [0:0]    state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          accept_c;
   logic          wr_c;
   logic          drop_c;
   logic          pop_c;

   // Handshake state register; ACK is the flopped state bit itself.
   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and per-cycle strobes; a pop while full frees the slot for a same-cycle write.
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      case (state)
         IDLE: if (RCV_REQ) begin
            state_nxt = ACKD;
            accept_c  = 1'b1;
         end
         ACKD: if (!RCV_REQ) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      pop_c  = rd_en && !empty;
      wr_c   = accept_c && !(full && !rd_en);
      drop_c = accept_c && full && !rd_en;
   end

   assign RCV_ACK = (state == ACKD);
   assign empty   = (count == CW'(0));
   assign full    = (count == CW'(DEPTH));
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_c) mem[wr_ptr] <= RCV_Data;
   end

   // Pointers wrap naturally at AW bits.
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (wr_c)  wr_ptr <= wr_ptr + AW'(1);
         if (pop_c) rd_ptr <= rd_ptr + AW'(1);
         if (wr_c && !pop_c)      count <= count + CW'(1);
         else if (pop_c && !wr_c) count <= count - CW'(1);
         if (drop_c)       overrun <= 1'b1;
         else if (ovr_clr) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: handshake timing, fill/overflow, wrap, simultaneous ops, reset.
module tb_uart_rx_fifo;

   logic       clk;
   logic       clr;
   logic       RCV_REQ;
   logic [7:0] RCV_Data;
   logic       RCV_ACK;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [3:0] count;
   logic       overrun;
   logic       ovr_clr;

   int total = 0;
   int bad   = 0;

   uart_rx_fifo #(.DEPTH(8), .AW(3)) dut (
      .clk(clk), .clr(clr), .RCV_REQ(RCV_REQ), .RCV_Data(RCV_Data), .RCV_ACK(RCV_ACK),
      .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
      .overrun(overrun), .ovr_clr(ovr_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; outputs are settled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic handshake(input logic [7:0] d);
      RCV_Data = d;
      RCV_REQ  = 1'b1;
      step();
      step();
      RCV_REQ  = 1'b0;
      step();
   endtask

   task automatic pop();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      step();
      clr = 1'b0;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
      total++; if (RCV_ACK !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", RCV_ACK); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
   endtask

   task automatic test_single();
      RCV_Data = 8'hA5;
      RCV_REQ  = 1'b1;
      step();
      total++; if (RCV_ACK !== 1'b1) begin bad++; $display("FAIL single_ack_rise got=%b exp=1", RCV_ACK); end
      total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
      total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", rd_data); end
      for (int i = 0; i < 4; i++) step();
      total++; if (count !== 4'd1) begin bad++; $display("FAIL single_one_write got=%0d exp=1", count); end
      total++; if (RCV_ACK !== 1'b1) begin bad++; $display("FAIL single_ack_hold got=%b exp=1", RCV_ACK); end
      RCV_REQ = 1'b0;
      step();
      total++; if (RCV_ACK !== 1'b0) begin bad++; $display("FAIL single_ack_fall got=%b exp=0", RCV_ACK); end
      pop();
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b exp=1", empty); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 1; i <= 9; i++) begin
         handshake(8'(i));
         if (i == 8) begin
            total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
            total++; if (overrun !== 1'b0) begin bad++; $display("FAIL fill_no_ovr got=%b exp=0", overrun); end
         end
      end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL fill_overrun got=%b exp=1", overrun); end
      total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d exp=8", count); end
      for (int i = 1; i <= 8; i++) begin
         total++; if (rd_data !== 8'(i)) begin bad++; $display("FAIL fill_pop%0d got=%h exp=%h", i, rd_data, 8'(i)); end
         pop();
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_drained got=%b exp=1", empty); end
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 6; i++) handshake(8'h20 + 8'(i));
      for (int i = 0; i < 6; i++) pop();
      for (int i = 0; i < 6; i++) handshake(8'h10 + 8'(i));
      total++; if (count !== 4'd6) begin bad++; $display("FAIL wrap_count got=%0d exp=6", count); end
      for (int i = 0; i < 6; i++) begin
         total++; if (rd_data !== 8'h10 + 8'(i)) begin bad++; $display("FAIL wrap_pop%0d got=%h exp=%h", i, rd_data, 8'h10 + 8'(i)); end
         pop();
      end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_final_count got=%0d exp=0", count); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 8; i++) handshake(8'h30 + 8'(i));
      RCV_Data = 8'h55;
      RCV_REQ  = 1'b1;
      rd_en    = 1'b1;
      step();
      rd_en = 1'b0;
      total++; if (count !== 4'd8) begin bad++; $display("FAIL simul_full_count got=%0d exp=8", count); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL simul_full_ovr got=%b exp=0", overrun); end
      RCV_REQ = 1'b0;
      step();
      for (int i = 1; i <= 8; i++) begin
         total++;
         if (rd_data !== ((i == 8) ? 8'h55 : 8'h30 + 8'(i))) begin
            bad++; $display("FAIL simul_drain%0d got=%h exp=%h", i, rd_data, (i == 8) ? 8'h55 : 8'h30 + 8'(i));
         end
         pop();
      end
      RCV_Data = 8'h66;
      RCV_REQ  = 1'b1;
      rd_en    = 1'b1;
      step();
      rd_en = 1'b0;
      total++; if (count !== 4'd1) begin bad++; $display("FAIL simul_empty_count got=%0d exp=1", count); end
      total++; if (rd_data !== 8'h66) begin bad++; $display("FAIL simul_empty_data got=%h exp=66", rd_data); end
      RCV_REQ = 1'b0;
      step();
      pop();
   endtask

   task automatic test_empty_pop_ovr();
      rd_en = 1'b1;
      step();
      step();
      rd_en = 1'b0;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL empty_pop_empty got=%b exp=1", empty); end
      for (int i = 0; i < 8; i++) handshake(8'h40 + 8'(i));
      RCV_Data = 8'h77;
      RCV_REQ  = 1'b1;
      ovr_clr  = 1'b1;
      step();
      ovr_clr = 1'b0;
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
      total++; if (RCV_ACK !== 1'b1) begin bad++; $display("FAIL ovr_drop_ack got=%b exp=1", RCV_ACK); end
      RCV_REQ = 1'b0;
      step();
      total++; if (rd_data !== 8'h40) begin bad++; $display("FAIL ovr_head got=%h exp=40", rd_data); end
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic test_reset_mid();
      handshake(8'h81);
      handshake(8'h82);
      RCV_Data = 8'h83;
      RCV_REQ  = 1'b1;
      step();
      total++; if (count !== 4'd3 || RCV_ACK !== 1'b1) begin bad++; $display("FAIL mid_pre got count=%0d ack=%b exp count=3 ack=1", count, RCV_ACK); end
      clr = 1'b1;
      step();
      clr = 1'b0;
      total++; if (RCV_ACK !== 1'b0) begin bad++; $display("FAIL mid_clr_ack got=%b exp=0", RCV_ACK); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_clr_count got=%0d exp=0", count); end
      step();
      total++; if (RCV_ACK !== 1'b1) begin bad++; $display("FAIL mid_reack got=%b exp=1", RCV_ACK); end
      total++; if (count !== 4'd1) begin bad++; $display("FAIL mid_rewrite_count got=%0d exp=1", count); end
      total++; if (rd_data !== 8'h83) begin bad++; $display("FAIL mid_rewrite_data got=%h exp=83", rd_data); end
      RCV_REQ = 1'b0;
      step();
   endtask

   initial begin
      clr      = 1'b0;
      RCV_REQ  = 1'b0;
      RCV_Data = 8'h00;
      rd_en    = 1'b0;
      ovr_clr  = 1'b0;
      #2;
      test_reset();
      test_single();
      test_fill_overflow();
      test_wrap();
      test_simultaneous();
      test_empty_pop_ovr();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
